fpnew_aux_lanes: RTL and testbench
==================================

# fpnew_aux_lanes

Parametrised successor to the FPNew aux/handshake chain. It carries the tag, aux data and a per-item lane mask through `NumPipeRegs` stages of elastic valid/ready pipeline. It drives per-stage, per-lane register enables, so that only lanes active for an item clock their datapath registers. It also reports occupancy, and an optional output spill stage cuts the combinational ready path. It sits beside the lane datapaths inside an FPNew operation-group block and keeps all lanes in lockstep.

## Interface
Parameters:
- `NumPipeRegs`, 0, number of register stages; 0 means a combinational pass-through.
- `NumLanes`, 1, number of datapath lanes controlled by the chain.
- `TagType`, logic, opaque tag type.
- `AuxType`, logic, opaque aux type.

Ports:
- `clk_i`  in  1  clock; all flops are rising-edge.
- `rst_i`  in  1  reset; **synchronous, active-high**.
- `tag_i`  in  TagType  input tag.
- `aux_i`  in  AuxType  input aux data.
- `lane_mask_i`  in  NumLanes  lanes used by this item.
- `in_valid_i`  in  1  upstream valid.
- `in_ready_o`  out  1  upstream ready.
- `flush_i`  in  1  synchronous kill of all in-flight items.
- `tag_o`  out  TagType  output tag.
- `aux_o`  out  AuxType  output aux data.
- `lane_mask_o`  out  NumLanes  output lane mask.
- `out_valid_o`  out  1  downstream valid.
- `out_ready_i`  in  1  downstream ready.
- `reg_enable_o`  out  NumPipeRegs×NumLanes  enable for lane datapath registers, indexed [stage][lane].
- `reg_ena_i`  in  NumPipeRegs×NumLanes  external enable override; ORed into `reg_enable_o`.
- `busy_o`  out  1  high when any item is valid, including the input.
- `count_o`  out  CntWidth  number of valid items held in registers.

## Operation
- Stage i is the content after i registers. Stage 0 is the input.
- ready[i] = ready[i+1] | ~valid[i+1].
- ready[NumPipeRegs] = `out_ready_i`, or the spill stage's ready when the spill stage is compiled in.
- valid[i+1] loads valid[i] when ready[i] is high.
- Stage advance: adv[i] = ready[i] & valid[i].
- `reg_enable_o[i][l]` = (adv[i] & mask[i][l]) | `reg_ena_i[i][l]`.
- tag, aux and mask registers load on adv[i] only. A bubble never overwrites held data.
- `in_ready_o` = ready[0] & ~`flush_i`. An item offered during flush is not accepted.
- Flush clears every valid register and the spill stage at the next edge; data registers are untouched.
- A mask of all zeros is legal. The item still propagates, but no lane enables assert.
- `count_o` is updated every cycle: +1 when an item enters stage 1, −1 when an item leaves the last register.
  - Both events in the same cycle leave the count unchanged.
  - Range is 0..NumPipeRegs, plus 1 with spill.
  - Flush or reset forces the count to 0.
- `busy_o` = `in_valid_i` | (`count_o` != 0).
- With `NumPipeRegs` = 0 and no spill: all outputs equal the inputs combinationally, `count_o` = 0 and `reg_enable_o` is empty.

## Timing
- Reset values:
  - all valids 0, so `out_valid_o` = 0 and `busy_o` follows `in_valid_i`;
  - `count_o` = 0;
  - `tag_o`, `aux_o` and `lane_mask_o` = '0;
  - spill stage empty.
- Latency is `NumPipeRegs` cycles with no stall; the spill stage adds 0 cycles when empty.
- Throughput is 1 item per cycle at full occupancy when `out_ready_i` is held at 1.
- When the pipe is full and `out_ready_i` = 0, `in_ready_o` = 0 in the same cycle (combinational without spill).
- Reset mid-operation behaves as flush and also clears the data registers.
- Reset has priority over flush, and flush has priority over advance.

## Configuration
- `FPNEW_AUX_SPILL_EN` defined:
  - adds a 1-entry spill register after the last stage;
  - ready[NumPipeRegs] is the registered value ~spill_full;
  - no combinational path from `out_ready_i` to `in_ready_o`.
- Not defined: no spill stage, and the ready path is combinational end to end.

## Structure
- Package `fpnew_aux_pkg` holds:
  - `cnt_width(NumPipeRegs, spill)`, returning $clog2(NumPipeRegs+2);
  - a helper typedef for the packed stage payload {tag, aux, mask}.
- Sub-module `fpnew_aux_stage`: one elastic stage with valid flop, payload flop and per-lane enable generation. It is instantiated NumPipeRegs times, plus once for the spill stage.

## Test plan
- NumPipeRegs=3, NumLanes=4, `out_ready_i`=1, items tag 1..5, mask 4'b0101:
  - outputs appear in cycles 3..7 in order;
  - `reg_enable_o[i]` = 4'b0101 on advancing cycles.
- Fill 3 items with `out_ready_i`=0:
  - `count_o`=3 and `in_ready_o`=0;
  - release ready → one output per cycle, and the count decrements 3→0.
- Bubble collapse: items in stages 1 and 3 only, `out_ready_i`=0, new input offered → accepted. The stage-2 bubble is popped, and data is not corrupted.
- `flush_i` with 3 items in flight and `in_valid_i`=1:
  - next cycle `count_o`=0 and `out_valid_o`=0;
  - the input was not accepted.
- Reset asserted mid-stream → next edge all valids 0, `tag_o`=0 and `count_o`=0. `reg_ena_i[1]`=4'b1000 forces `reg_enable_o[1][3]` high while the pipe is idle.
- `FPNEW_AUX_SPILL_EN`: `out_ready_i` toggled randomly for 1000 cycles →
  - `in_ready_o` is never a combinational function of `out_ready_i`;
  - item order is preserved and none are lost;
  - the count peaks at 4.

Source files
------------

// File: rtl/fpnew_aux_pkg.sv
// -----------------------------------------------------------------------------
// fpnew_aux_pkg
// Shared definitions for the FPNew aux/handshake lane chain.
//
// Build option:
//   FPNEW_AUX_SPILL_EN - when defined, a 1-entry spill register is placed
//                        after the last pipeline stage (SpillEn = 1).
//
// Contents:
//   SpillEn         - build-time flag mirroring FPNEW_AUX_SPILL_EN
//   cnt_width()     - width of the occupancy counter port
//   payload_bits()  - packed width of one stage payload {tag, aux, mask}
// -----------------------------------------------------------------------------
package fpnew_aux_pkg;

`ifdef FPNEW_AUX_SPILL_EN
  localparam bit SpillEn = 1'b1;
`else
  localparam bit SpillEn = 1'b0;
`endif

  // The counter is always wide enough for NumPipeRegs+1 entries, so the
  // port width stays the same whether or not the spill entry is built.
  function automatic int unsigned cnt_width(int unsigned num_pipe_regs, bit spill);
    return unsigned'($clog2(num_pipe_regs + 2));
  endfunction

  // Width of the packed stage payload {tag, aux, mask}; handy when a lane
  // datapath wants to size a side buffer for the control word.
  function automatic int unsigned payload_bits(int unsigned tag_bits,
                                               int unsigned aux_bits,
                                               int unsigned num_lanes);
    return tag_bits + aux_bits + num_lanes;
  endfunction

endpackage

// File: rtl/fpnew_aux_stage.sv
// -----------------------------------------------------------------------------
// fpnew_aux_stage
// One elastic valid/ready register stage carrying an opaque payload.
//
// Parameters:
//   payload_t - packed payload type held by the stage
//   RegReady  - 0: in_ready_o = out_ready_i | ~valid (combinational, pipe stage)
//               1: in_ready_o = ~valid (registered, used as the spill entry)
//
// Ports:
//   clk_i, rst_i  - rising-edge clock, synchronous active-high reset
//   flush_i       - clears the valid flop at the next edge, blocks loading
//   in_valid_i    - upstream valid
//   in_data_i     - upstream payload
//   in_ready_o    - upstream ready (see RegReady)
//   out_valid_o   - stage valid
//   out_data_o    - stage payload
//   out_ready_i   - downstream ready
//   adv_o         - an item is being captured into this stage this cycle
// -----------------------------------------------------------------------------
module fpnew_aux_stage
  import fpnew_aux_pkg::*;
#(
  parameter type payload_t = logic,
  parameter bit  RegReady  = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     in_valid_i,
  input  payload_t in_data_i,
  output logic     in_ready_o,
  output logic     out_valid_o,
  output payload_t out_data_o,
  input  logic     out_ready_i,
  output logic     adv_o
);

  logic     valid_q;
  payload_t data_q;
  logic     load;

  // The stage may take a new value whenever it is empty or being drained.
  // An empty stage therefore pops bubbles out of the pipe.
  assign load       = out_ready_i | ~valid_q;
  assign in_ready_o = RegReady ? ~valid_q : load;

  // Flush wins over advance: nothing is captured while flushing.
  assign adv_o      = load & in_valid_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of its neighbours.
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, so tag/aux/mask read '0 after reset;
      // flush deliberately leaves it alone and only drops the valid.
      data_q  <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= in_valid_i;
      end
      // Bubbles never overwrite held data.
      if (adv_o) begin
        data_q <= in_data_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fpnew_aux_lanes.sv
// -----------------------------------------------------------------------------
// fpnew_aux_lanes
// Elastic tag/aux/lane-mask chain running beside the lane datapaths of an
// FPNew operation group. It generates per-stage, per-lane register enables
// so only the lanes an item uses clock their datapath registers.
//
// Build option:
//   FPNEW_AUX_SPILL_EN - adds a 1-entry spill register after the last stage;
//                        ready into the last stage becomes the registered
//                        ~spill_full, cutting the out_ready_i -> in_ready_o
//                        path.
//
// Parameters: NumPipeRegs (0 = pass-through), NumLanes, TagType, AuxType.
//
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   tag_i, aux_i           - input tag / aux data
//   lane_mask_i            - lanes used by the incoming item
//   in_valid_i/in_ready_o  - upstream handshake
//   flush_i                - kill all in-flight items
//   tag_o, aux_o           - output tag / aux data
//   lane_mask_o            - output lane mask
//   out_valid_o/out_ready_i- downstream handshake
//   reg_enable_o[s][l]     - lane datapath register enables per stage
//   reg_ena_i[s][l]        - external enable override, ORed in
//   busy_o                 - any valid item, including the input
//   count_o                - valid items held in registers (spill included)
// With NumPipeRegs = 0 the enable ports keep a single row that only carries
// the external override.
// -----------------------------------------------------------------------------
module fpnew_aux_lanes
  import fpnew_aux_pkg::*;
#(
  parameter int unsigned  NumPipeRegs = 0,
  parameter int unsigned  NumLanes    = 1,
  parameter type          TagType     = logic,
  parameter type          AuxType     = logic,
  localparam int unsigned EnRows      = (NumPipeRegs > 0) ? NumPipeRegs : 1,
  localparam int unsigned CntWidth    = cnt_width(NumPipeRegs, SpillEn)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  TagType                           tag_i,
  input  AuxType                           aux_i,
  input  logic [NumLanes-1:0]              lane_mask_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             flush_i,
  output TagType                           tag_o,
  output AuxType                           aux_o,
  output logic [NumLanes-1:0]              lane_mask_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [EnRows-1:0][NumLanes-1:0]  reg_enable_o,
  input  logic [EnRows-1:0][NumLanes-1:0]  reg_ena_i,
  output logic                             busy_o,
  output logic [CntWidth-1:0]              count_o
);

  typedef struct packed {
    TagType              tag;
    AuxType              aux;
    logic [NumLanes-1:0] mask;
  } payload_t;

  // Index i is the content after i registers; index 0 is the input.
  logic [NumPipeRegs:0] valid;
  logic [NumPipeRegs:0] ready;
  logic [NumPipeRegs:0] adv;
  payload_t             stage_data [NumPipeRegs+1];
  payload_t             out_data;
  logic                 cnt_inc;
  logic                 cnt_dec;
  logic [CntWidth-1:0]  count_q;

  assign valid[0]      = in_valid_i;
  assign stage_data[0] = '{tag: tag_i, aux: aux_i, mask: lane_mask_i};

  for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
    fpnew_aux_stage #(
      .payload_t (payload_t),
      .RegReady  (1'b0)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (valid[k]),
      .in_data_i   (stage_data[k]),
      .in_ready_o  (ready[k]),
      .out_valid_o (valid[k+1]),
      .out_data_o  (stage_data[k+1]),
      .out_ready_i (ready[k+1]),
      .adv_o       (adv[k])
    );
  end

  // Item leaves the last pipeline position (into the spill entry or out).
  assign adv[NumPipeRegs] = ready[NumPipeRegs] & valid[NumPipeRegs] & ~flush_i;

`ifdef FPNEW_AUX_SPILL_EN
  logic     spill_valid;
  logic     spill_adv;
  payload_t spill_data;

  // While empty the spill entry is transparent: the last stage drives the
  // output directly and is captured only if downstream stalls. While full,
  // the spill entry drives the output and holds off the last stage.
  fpnew_aux_stage #(
    .payload_t (payload_t),
    .RegReady  (1'b1)
  ) u_spill (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (valid[NumPipeRegs] & ~out_ready_i),
    .in_data_i   (stage_data[NumPipeRegs]),
    .in_ready_o  (ready[NumPipeRegs]),
    .out_valid_o (spill_valid),
    .out_data_o  (spill_data),
    .out_ready_i (out_ready_i),
    .adv_o       (spill_adv)
  );

  assign out_valid_o = spill_valid | valid[NumPipeRegs];
  assign out_data    = spill_valid ? spill_data : stage_data[NumPipeRegs];
  // Leaving the last stage into the spill entry keeps the item counted.
  assign cnt_dec     = (adv[NumPipeRegs] & ~spill_adv) | (spill_valid & out_ready_i);
`else
  assign ready[NumPipeRegs] = out_ready_i;
  assign out_valid_o        = valid[NumPipeRegs];
  assign out_data           = stage_data[NumPipeRegs];
  assign cnt_dec            = adv[NumPipeRegs];
`endif

  // With NumPipeRegs = 0 and no spill, adv[0] is both entry and exit, so the
  // count stays at zero.
  assign cnt_inc = adv[0];

  assign in_ready_o  = ready[0] & ~flush_i;
  assign tag_o       = out_data.tag;
  assign aux_o       = out_data.aux;
  assign lane_mask_o = out_data.mask;

  always_comb begin
    // NOTE: every row gets a default before the loop so no latch is inferred
    // and the single NumPipeRegs = 0 row is still driven.
    reg_enable_o = reg_ena_i;
    for (int i = 0; i < NumPipeRegs; i++) begin
      reg_enable_o[i] = reg_ena_i[i] | ({NumLanes{adv[i]}} & stage_data[i].mask);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CntWidth'(cnt_inc) - CntWidth'(cnt_dec);
    end
  end

  assign count_o = count_q;
  assign busy_o  = in_valid_i | (count_q != '0);

endmodule

// File: tb/tb_fpnew_aux_lanes.sv
// -----------------------------------------------------------------------------
// tb_fpnew_aux_lanes
// Directed bench for fpnew_aux_lanes with NumPipeRegs = 3, NumLanes = 4,
// 8-bit tag and aux. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge. With FPNEW_AUX_SPILL_EN defined the bench
// runs the reset check and a randomised back-pressure run instead of the
// no-spill timing scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpnew_aux_lanes;

  logic             clk_i;
  logic             rst_i;
  logic [7:0]       tag_i;
  logic [7:0]       aux_i;
  logic [3:0]       lane_mask_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             flush_i;
  logic [7:0]       tag_o;
  logic [7:0]       aux_o;
  logic [3:0]       lane_mask_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [2:0][3:0]  reg_enable_o;
  logic [2:0][3:0]  reg_ena_i;
  logic             busy_o;
  logic [2:0]       count_o;

  int n_cmp = 0;
  int n_mis = 0;

  fpnew_aux_lanes #(
    .NumPipeRegs (3),
    .NumLanes    (4),
    .TagType     (logic [7:0]),
    .AuxType     (logic [7:0])
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tag_i        (tag_i),
    .aux_i        (aux_i),
    .lane_mask_i  (lane_mask_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .flush_i      (flush_i),
    .tag_o        (tag_o),
    .aux_o        (aux_o),
    .lane_mask_o  (lane_mask_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .reg_enable_o (reg_enable_o),
    .reg_ena_i    (reg_ena_i),
    .busy_o       (busy_o),
    .count_o      (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic [3:0] m);
    in_valid_i  = v;
    tag_i       = t;
    aux_i       = t + 8'h10;
    lane_mask_i = m;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b0, 8'h00, 4'h0);
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    n_cmp++; if (count_o !== 3'd0) begin n_mis++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_cmp++; if (tag_o !== 8'h00 || aux_o !== 8'h00 || lane_mask_o !== 4'h0) begin
      n_mis++; $display("FAIL reset_data: got tag %h aux %h mask %b want zeros", tag_o, aux_o, lane_mask_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy_idle: got %b want 0", busy_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    in_valid_i = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL reset_busy_follows_in: got %b want 1", busy_o); end
    in_valid_i = 1'b0;
    next_cycle();
    rst_i = 1'b0;
    next_cycle();
  endtask

  // Five back-to-back items, out_ready_i held high.
  task automatic test_stream();
    logic [3:0] exp_en;
    int         exp_cnt;
    out_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(c < 5, 8'(c + 1), 4'b0101);
      @(negedge clk_i);
      for (int s = 0; s < 3; s++) begin
        exp_en = (c >= s && c <= s + 4) ? 4'b0101 : 4'b0000;
        n_cmp++; if (reg_enable_o[s] !== exp_en) begin
          n_mis++; $display("FAIL stream_reg_en c%0d s%0d: got %b want %b", c, s, reg_enable_o[s], exp_en); end
      end
      exp_cnt = 0;
      for (int s = 1; s <= 3; s++) if (c - s >= 0 && c - s <= 4) exp_cnt++;
      n_cmp++; if (count_o !== 3'(exp_cnt)) begin
        n_mis++; $display("FAIL stream_count c%0d: got %0d want %0d", c, count_o, exp_cnt); end
      n_cmp++; if (out_valid_o !== (c >= 3 && c <= 7)) begin
        n_mis++; $display("FAIL stream_out_valid c%0d: got %b", c, out_valid_o); end
      if (c >= 3 && c <= 7) begin
        n_cmp++; if (tag_o !== 8'(c - 2) || aux_o !== 8'(c - 2 + 16) || lane_mask_o !== 4'b0101) begin
          n_mis++; $display("FAIL stream_data c%0d: got tag %h aux %h mask %b want tag %h", c, tag_o, aux_o, lane_mask_o, 8'(c - 2)); end
      end
      next_cycle();
    end
  endtask

  // Fill three items under back-pressure, then drain one per cycle.
  task automatic test_back_pressure();
    out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'(8'h21 + c), 4'(1 << c));
      next_cycle();
    end
    drive(1'b0, 8'h00, 4'h0);
    @(negedge clk_i);
    n_cmp++; if (count_o !== 3'd3) begin n_mis++; $display("FAIL bp_full_count: got %0d want 3", count_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready: got %b want 0", in_ready_o); end
    n_cmp++; if (reg_enable_o !== 12'h000) begin n_mis++; $display("FAIL bp_stalled_en: got %h want 000", reg_enable_o); end
    next_cycle();
    out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_cmp++; if (count_o !== 3'(3 - c)) begin n_mis++; $display("FAIL bp_drain_count c%0d: got %0d want %0d", c, count_o, 3 - c); end
      n_cmp++; if (out_valid_o !== (c < 3)) begin n_mis++; $display("FAIL bp_drain_valid c%0d: got %b", c, out_valid_o); end
      if (c < 3) begin
        n_cmp++; if (tag_o !== 8'(8'h21 + c)) begin n_mis++; $display("FAIL bp_drain_tag c%0d: got %h want %h", c, tag_o, 8'(8'h21 + c)); end
      end
      next_cycle();
    end
  endtask

  // Items in stages 1 and 3 only; a new input must collapse the bubble.
  task automatic test_bubble();
    out_ready_i = 1'b0;
    drive(1'b1, 8'h31, 4'b0001); next_cycle();
    drive(1'b0, 8'h00, 4'b0000); next_cycle();
    drive(1'b1, 8'h32, 4'b0010); next_cycle();
    drive(1'b1, 8'h33, 4'b1100);
    @(negedge clk_i);
    n_cmp++; if (count_o !== 3'd2) begin n_mis++; $display("FAIL bubble_count_before: got %0d want 2", count_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_mis++; $display("FAIL bubble_in_ready: got %b want 1", in_ready_o); end
    n_cmp++; if (reg_enable_o !== {4'b0000, 4'b0010, 4'b1100}) begin
      n_mis++; $display("FAIL bubble_reg_en: got %h want 02c", reg_enable_o); end
    next_cycle();
    drive(1'b0, 8'h00, 4'h0);
    @(negedge clk_i);
    n_cmp++; if (count_o !== 3'd3) begin n_mis++; $display("FAIL bubble_count_after: got %0d want 3", count_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL bubble_full_ready: got %b want 0", in_ready_o); end
    next_cycle();
    out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_cmp++; if (out_valid_o !== (c < 3)) begin n_mis++; $display("FAIL bubble_out_valid c%0d: got %b", c, out_valid_o); end
      if (c < 3) begin
        n_cmp++; if (tag_o !== 8'(8'h31 + c)) begin n_mis++; $display("FAIL bubble_order c%0d: got %h want %h", c, tag_o, 8'(8'h31 + c)); end
      end
      next_cycle();
    end
  endtask

  // An all-zero mask travels through without raising any lane enable.
  task automatic test_zero_mask();
    out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 8'h41, 4'b0000);
      @(negedge clk_i);
      n_cmp++; if (reg_enable_o !== 12'h000) begin n_mis++; $display("FAIL zmask_reg_en c%0d: got %h want 000", c, reg_enable_o); end
      if (c == 3) begin
        n_cmp++; if (out_valid_o !== 1'b1 || tag_o !== 8'h41 || lane_mask_o !== 4'b0000) begin
          n_mis++; $display("FAIL zmask_out: got valid %b tag %h mask %b want 1 41 0000", out_valid_o, tag_o, lane_mask_o); end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'(8'h51 + c), 4'b1111);
      next_cycle();
    end
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 8'h54, 4'b1111);
    @(negedge clk_i);
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL flush_in_ready: got %b want 0", in_ready_o); end
    next_cycle();
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 4'h0);
    @(negedge clk_i);
    n_cmp++; if (count_o !== 3'd0) begin n_mis++; $display("FAIL flush_count: got %0d want 0", count_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL flush_out_valid: got %b want 0", out_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    n_cmp++; if (tag_o !== 8'h51) begin n_mis++; $display("FAIL flush_data_kept: got %h want 51", tag_o); end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk_i);
      n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL flush_not_accepted c%0d: got %b want 0", c, out_valid_o); end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 8'(8'h61 + c), 4'b0110);
      next_cycle();
    end
    rst_i = 1'b1;
    drive(1'b0, 8'h00, 4'h0);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin
      n_mis++; $display("FAIL rstmid_state: got valid %b count %0d want 0 0", out_valid_o, count_o); end
    n_cmp++; if (tag_o !== 8'h00 || lane_mask_o !== 4'h0) begin
      n_mis++; $display("FAIL rstmid_data: got tag %h mask %b want 00 0000", tag_o, lane_mask_o); end
    reg_ena_i[1] = 4'b1000;
    #1;
    n_cmp++; if (reg_enable_o !== {4'b0000, 4'b1000, 4'b0000}) begin
      n_mis++; $display("FAIL ext_enable: got %h want 080", reg_enable_o); end
    reg_ena_i = '0;
    next_cycle();
  endtask

`ifdef FPNEW_AUX_SPILL_EN
  task automatic test_spill_random();
    logic [7:0] exp_q [$];
    logic [7:0] next_tag;
    logic       ir_a;
    logic       ir_b;
    logic       pushed;
    int         peak;
    next_tag = 8'h01;
    peak = 0;
    for (int c = 0; c < 1010; c++) begin
      out_ready_i = (c >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(c < 1000, next_tag, next_tag[3:0]);
      @(negedge clk_i);
      ir_a = in_ready_o;
      out_ready_i = ~out_ready_i;
      #1;
      ir_b = in_ready_o;
      out_ready_i = ~out_ready_i;
      #1;
      n_cmp++; if (ir_a !== ir_b) begin n_mis++; $display("FAIL spill_ready_path c%0d: in_ready changed with out_ready", c); end
      if (int'(count_o) > peak) peak = int'(count_o);
      if (out_valid_o && out_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++; $display("FAIL spill_extra_item c%0d: got %h, nothing expected", c, tag_o);
        end else begin
          if (tag_o !== exp_q[0]) begin n_mis++; $display("FAIL spill_order c%0d: got %h want %h", c, tag_o, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      pushed = in_valid_i && in_ready_o;
      if (pushed) begin
        exp_q.push_back(next_tag);
        next_tag = next_tag + 8'h01;
      end
      next_cycle();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL spill_lost: got %0d items left want 0", exp_q.size()); end
    n_cmp++; if (peak != 4) begin n_mis++; $display("FAIL spill_peak: got %0d want 4", peak); end
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    reg_ena_i   = '0;
    drive(1'b0, 8'h00, 4'h0);
    #1;
    test_reset();
`ifdef FPNEW_AUX_SPILL_EN
    test_spill_random();
`else
    test_stream();
    test_back_pressure();
    test_bubble();
    test_zero_mask();
    test_flush();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
